// File: rtl/axi_read_responder.sv
// axi_read_responder
//   AXI read-slave model sitting at the far end of the ROB's AR/R path.
//   Accepted AR requests are held in a small queue. Each entry becomes
//   eligible RESP_LATENCY cycles after it is accepted. Eligible bursts are
//   returned whole (never interleaved), either oldest-first or in an
//   LFSR-driven pseudo-random order when reorder_en=1.
//   Beat data is the beat address replicated across the data bus, so a bench
//   can recompute every beat it receives.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   ar_valid/ar_ready   AR handshake; ar_ready = queue not full
//   ar_id/addr/len/size/burst   AR request payload
//   reorder_en          1: pseudo-random selection among eligible entries
//   r_valid/r_ready     R handshake
//   r_id/r_data/r_resp/r_last   R beat payload, zero while no burst is active
module axi_read_responder #(
    parameter int                    ID_WIDTH     = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    RESP_WIDTH   = 2,
    parameter int                    DEPTH        = 8,
    parameter int                    RESP_LATENCY = 4,
    parameter logic [ADDR_WIDTH-1:0] MEM_BYTES    = ADDR_WIDTH'(32'h1_0000),
    parameter logic [15:0]           LFSR_SEED    = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    input  logic [ID_WIDTH-1:0]   ar_id,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic [7:0]            ar_len,
    input  logic [2:0]            ar_size,
    input  logic [1:0]            ar_burst,
    input  logic                  reorder_en,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [ID_WIDTH-1:0]   r_id,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [RESP_WIDTH-1:0] r_resp,
    output logic                  r_last
);

    localparam int         IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         SEQ_W = $clog2(2 * DEPTH);
    localparam logic [7:0] LAT   = 8'(RESP_LATENCY);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_BURST} state_t;

    state_t state, state_n;

    logic                             up;       // low only until the first edge after reset
    logic [DEPTH-1:0]                 vld;
    logic [DEPTH-1:0][ID_WIDTH-1:0]   q_id;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] q_addr;
    logic [DEPTH-1:0][7:0]            q_len;
    logic [DEPTH-1:0][2:0]            q_size;
    logic [DEPTH-1:0][1:0]            q_burst;
    logic [DEPTH-1:0][SEQ_W-1:0]      q_seq;
    logic [DEPTH-1:0][7:0]            q_wait;
    logic [SEQ_W-1:0]                 seq_cnt;
    logic [15:0]                      lfsr;
    logic [IDX_W-1:0]                 cur;
    logic [7:0]                       beat;

    logic                  full, accept, active, retire;
    logic [DEPTH-1:0]      elig;
    logic [IDX_W-1:0]      free_idx, sel_old, sel_rnd;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [RESP_WIDTH-1:0] resp_cur;

    // Sequence numbers wrap modulo 2*DEPTH; at most DEPTH are live, so a
    // forward distance below DEPTH means a was issued before b.
    function automatic logic is_older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        int d;
        d = (int'(b) + 2 * DEPTH - int'(a)) % (2 * DEPTH);
        return (d != 0) && (d < DEPTH);
    endfunction

    assign full     = &vld;
    assign ar_ready = up && !full;
    assign accept   = ar_valid && ar_ready;
    assign active   = (state == S_BURST);
    assign r_valid  = active;
    assign r_last   = active && (beat == q_len[cur]);
    assign retire   = active && r_ready && r_last;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) elig[i] = vld[i] && (q_wait[i] == LAT);
    end

    // Lowest free slot: scan downward so the last hit wins.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        logic found;
        found   = 1'b0;
        sel_old = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i] && (!found || is_older(q_seq[i], q_seq[sel_old]))) begin
                sel_old = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

    // First eligible slot at or above the LFSR start point, wrapping around.
    // Scanning the offsets from high to low lets the smallest offset win.
    always_comb begin
        int start;
        start   = int'(lfsr[IDX_W-1:0]) % DEPTH;
        sel_rnd = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig[(start + i) % DEPTH]) sel_rnd = IDX_W'((start + i) % DEPTH);
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] base, off, incr, mask;
        base = q_addr[cur];
        off  = ADDR_WIDTH'(beat) << q_size[cur];
        incr = base + off;
        mask = ((ADDR_WIDTH'(q_len[cur]) + ADDR_WIDTH'(1)) << q_size[cur]) - ADDR_WIDTH'(1);
        case (q_burst[cur])
            BURST_FIXED: beat_addr = base;
            BURST_WRAP:  beat_addr = (base & ~mask) | (incr & mask);
            default:     beat_addr = incr;   // INCR and the reserved encoding
        endcase
    end

    always_comb begin
        resp_cur = '0;
        if (q_addr[cur] >= MEM_BYTES)        resp_cur = RESP_WIDTH'(2'b11);
        else if (q_burst[cur] == BURST_RSVD) resp_cur = RESP_WIDTH'(2'b10);
    end

    assign r_id   = active ? q_id[cur] : '0;
    assign r_resp = active ? resp_cur  : '0;

    always_comb begin
        r_data = '0;
        if (active) begin
            for (int i = 0; i < DATA_WIDTH; i++) r_data[i] = beat_addr[i % ADDR_WIDTH];
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (|elig) state_n = S_SELECT;
            S_SELECT: state_n = S_BURST;
            S_BURST:  if (retire) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            up      <= 1'b0;
            vld     <= '0;
            seq_cnt <= '0;
            lfsr    <= LFSR_SEED;
            cur     <= '0;
            beat    <= '0;
        end else begin
            state <= state_n;
            up    <= 1'b1;
            // Galois form of x^16+x^14+x^13+x^11
            lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            if (state == S_SELECT) begin
                cur  <= reorder_en ? sel_rnd : sel_old;
                beat <= '0;
            end else if (active && r_ready) begin
                beat <= beat + 8'd1;
            end
            // The retiring slot is still marked busy, so an accept in the
            // same cycle always lands elsewhere.
            if (retire) vld[cur] <= 1'b0;
            if (accept) begin
                vld[free_idx] <= 1'b1;
                seq_cnt       <= (seq_cnt == SEQ_W'(2 * DEPTH - 1)) ? '0 : seq_cnt + SEQ_W'(1);
            end
        end
    end

    // Payload and wait counters are only looked at while the slot is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && q_wait[i] != LAT) q_wait[i] <= q_wait[i] + 8'd1;
        end
        if (accept) begin
            q_id[free_idx]    <= ar_id;
            q_addr[free_idx]  <= ar_addr;
            q_len[free_idx]   <= ar_len;
            q_size[free_idx]  <= ar_size;
            q_burst[free_idx] <= ar_burst;
            q_seq[free_idx]   <= seq_cnt;
            q_wait[free_idx]  <= '0;
        end
    end

endmodule
